mem_a_skew: RTL and testbench

MEM_A_SKEW -- requirements
Module: mem_a_skew

---
 rtl/mem_a_skew.sv | 90 +++++++++
 tb/tb_mem_a_skew.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_a_skew.sv
// Skewed row feeder for a systolic array: row i is a DIM+i deep shift register
// loaded with i leading zeros, so A[i][0] reaches Aout[i] after i shifts.
module mem_a_skew #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      WrEn,
    input  logic [$clog2(DIM)-1:0]    Arow,
    input  logic signed [BITS_AB-1:0] Ain  [DIM],
    input  logic                      en,
    output logic signed [BITS_AB-1:0] Aout [DIM],
    output logic                      busy,
    output logic                      done,
    output logic                      wr_err
);

    localparam int              AW   = $clog2(DIM);
    localparam int              CW   = $clog2(2 * DIM);
    localparam logic [CW-1:0]   LAST = CW'(2 * DIM - 2);

    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic          r_wr_err;

    logic w_row_ok;
    logic w_wr_ok;
    logic w_wr_rej;
    logic w_last;

    // Widened compare so a non-power-of-two DIM still rejects out-of-range rows.
    assign w_row_ok = (32'(Arow) < DIM);
    assign busy     = (r_cnt != '0);
    assign w_wr_ok  = WrEn & ~en & ~clr & ~busy & w_row_ok;
    assign w_wr_rej = WrEn & ~clr & ~w_wr_ok;
    assign w_last   = (r_cnt == LAST);

    assign done   = r_done;
    assign wr_err = r_wr_err;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else if (clr) begin
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_rej;
            r_done   <= en & w_last;
            if (en) begin
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
        end
    end

    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        localparam int LEN = DIM + gi;

        logic signed [BITS_AB-1:0] r_sr [LEN];
        logic                      w_sel;

        assign w_sel = w_wr_ok && (Arow == AW'(gi));

        // NOTE: these are flops, not a RAM macro, so the whole array is reset;
        // a mid-sequence reset must leave Aout at zero immediately.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j < LEN; j++) r_sr[j] <= '0;
            end else if (clr) begin
                for (int j = 0; j < LEN; j++) r_sr[j] <= '0;
            end else if (en) begin
                for (int j = 0; j < LEN - 1; j++) r_sr[j] <= r_sr[j+1];
                r_sr[LEN-1] <= '0;
            end else if (w_sel) begin
                for (int j = 0; j < gi; j++) r_sr[j] <= '0;
                for (int k = 0; k < DIM; k++) r_sr[gi+k] <= Ain[k];
            end
        end

        assign Aout[gi] = r_sr[0];
    end

endmodule

// File: tb/tb_mem_a_skew.sv
// Self-checking bench for mem_a_skew: directed scenarios plus random traffic,
// compared against a queue-based row model.
module tb_mem_a_skew;

    localparam int DIM  = 4;
    localparam int BITS = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clr;
    logic                   WrEn;
    logic [1:0]             Arow;
    logic signed [BITS-1:0] Ain  [DIM];
    logic                   en;
    logic signed [BITS-1:0] Aout [DIM];
    logic                   busy;
    logic                   done;
    logic                   wr_err;

    always #5 clk = ~clk;

    mem_a_skew #(.BITS_AB(BITS), .DIM(DIM)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .WrEn   (WrEn),
        .Arow   (Arow),
        .Ain    (Ain),
        .en     (en),
        .Aout   (Aout),
        .busy   (busy),
        .done   (done),
        .wr_err (wr_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Each row is a FIFO of values still to be presented; head is Aout[i].
    byte m_row [DIM][$];
    int  m_cnt;
    bit  m_done;
    bit  m_err;

    function automatic void model_reset();
        for (int i = 0; i < DIM; i++) begin
            m_row[i].delete();
            for (int j = 0; j < DIM + i; j++) m_row[i].push_back(8'sd0);
        end
        m_cnt  = 0;
        m_done = 0;
        m_err  = 0;
    endfunction

    function automatic void model_edge();
        bit ok;
        int r;
        if (clr) begin
            model_reset();
            return;
        end
        r  = int'(Arow);
        ok = WrEn && !en && (m_cnt == 0) && (r < DIM);
        m_err  = WrEn && !ok;
        m_done = 0;
        if (en) begin
            for (int i = 0; i < DIM; i++) begin
                void'(m_row[i].pop_front());
                m_row[i].push_back(8'sd0);
            end
            m_done = (m_cnt == 2 * DIM - 2);
            m_cnt  = m_done ? 0 : m_cnt + 1;
        end else if (ok) begin
            m_row[r].delete();
            for (int j = 0; j < r; j++) m_row[r].push_back(8'sd0);
            for (int k = 0; k < DIM; k++) m_row[r].push_back(Ain[k]);
        end
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < DIM; i++)
            check($sformatf("%s aout%0d", tag, i), Aout[i], m_row[i][0]);
        check({tag, " busy"}, busy, (m_cnt != 0));
        check({tag, " done"}, done, m_done);
        check({tag, " wr_err"}, wr_err, m_err);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    task automatic idle_inputs();
        WrEn = 0;
        en   = 0;
        clr  = 0;
        Arow = '0;
        for (int k = 0; k < DIM; k++) Ain[k] = '0;
    endtask

    task automatic load_matrix(input string tag);
        for (int i = 0; i < DIM; i++) begin
            WrEn = 1;
            Arow = 2'(i);
            for (int k = 0; k < DIM; k++) Ain[k] = 8'(16 * i + k);
            cycle(tag);
        end
        WrEn = 0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        WrEn  = 0;
        en    = 1;
        while (m_cnt != 0 && guard < 20) begin
            cycle(tag);
            guard++;
        end
        check({tag, " drain_bound"}, (guard < 20), 1);
        en = 0;
    endtask

    initial begin
        int s;
        int en_count;
        bit en_pat [4];

        idle_inputs();
        rst = 1;
        #12;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst = 0;

        // Full load of A[i][k]=16i+k then 7 shifts.
        load_matrix("load");
        check("load row0", Aout[0], 0);
        check("load row3", Aout[3], 0);
        en = 1;
        for (s = 1; s <= 2 * DIM - 1; s++) begin
            cycle("feed");
            check($sformatf("feed row0 s%0d", s), Aout[0], (s < 4) ? s : 0);
            check($sformatf("feed row3 s%0d", s), Aout[3],
                  (s >= 3 && s < 7) ? 48 + s - 3 : 0);
        end
        check("feed done", done, 1);
        check("feed busy", busy, 0);
        en = 0;
        cycle("post_feed");
        check("done one-shot", done, 0);

        // Row 2 all -1: leading zeros hide it for two shifts.
        WrEn = 1;
        Arow = 2'd2;
        for (int k = 0; k < DIM; k++) Ain[k] = -8'sd1;
        cycle("neg_write");
        check("neg lead zero", Aout[2], 0);
        WrEn = 0;
        en   = 1;
        cycle("neg_shift1");
        cycle("neg_shift2");
        check("neg after 2", Aout[2], -1);
        drain("neg_drain");

        // Write attempt during a busy, shifting sequence.
        en = 1;
        cycle("busy_start");
        WrEn = 1;
        Arow = 2'd1;
        for (int k = 0; k < DIM; k++) Ain[k] = 8'h55;
        cycle("busy_write");
        check("busy wr_err", wr_err, 1);
        WrEn = 0;
        cycle("busy_after");
        check("busy wr_err once", wr_err, 0);
        en   = 0;
        WrEn = 1;
        cycle("busy_paused_write");
        WrEn = 0;
        drain("busy_drain");

        // Pausing en mid-sequence.
        load_matrix("pause_load");
        en_pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
        en_count = 0;
        for (int n = 0; n < 30 && en_count < 2 * DIM - 1; n++) begin
            en = (n >= 2 && n < 6) ? en_pat[n-2] : 1'b1;
            if (en) en_count++;
            cycle("pause");
        end
        check("pause done", done, 1);
        check("pause en count", en_count, 2 * DIM - 1);
        en = 0;
        cycle("pause_idle");

        // Asynchronous reset between edges at cnt=3.
        load_matrix("rst_load");
        en = 1;
        for (int n = 0; n < 3; n++) cycle("rst_feed");
        en = 0;
        cycle("rst_hold");
        #2;
        rst = 1;
        #1;
        for (int i = 0; i < DIM; i++) check($sformatf("async rst aout%0d", i), Aout[i], 0);
        check("async rst busy", busy, 0);
        check("async rst done", done, 0);
        model_reset();
        #1;
        rst  = 0;
        WrEn = 1;
        Arow = 2'd0;
        for (int k = 0; k < DIM; k++) Ain[k] = 8'(100 + k);
        cycle("rst_write");
        check("rst write accepted", Aout[0], 100);
        WrEn = 0;

        // Synchronous clear overrides WrEn and en.
        en = 1;
        cycle("clr_feed1");
        cycle("clr_feed2");
        clr  = 1;
        WrEn = 1;
        cycle("clr");
        for (int i = 0; i < DIM; i++) check($sformatf("clr aout%0d", i), Aout[i], 0);
        check("clr busy", busy, 0);
        check("clr wr_err", wr_err, 0);
        check("clr done", done, 0);
        idle_inputs();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            clr  = ($urandom_range(0, 49) == 0);
            WrEn = ($urandom_range(0, 2) == 0);
            en   = ($urandom_range(0, 9) < 4);
            Arow = 2'($urandom);
            for (int k = 0; k < DIM; k++) Ain[k] = 8'($urandom);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
